// File: rtl/simple_dma_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : simple_dma_controller_if
// Description : Device-DMA handshake plus core DMA memory-port signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface simple_dma_controller_if;
  logic        dma_rqst;
  logic        dma_rd_wr;
  logic [15:0] dma_start_address;
  logic [15:0] dma_num_words;
  logic        dev_ack;
  logic [15:0] dev_out;
  logic [15:0] dev_in;
  logic        dma_ack;
  logic        dma_end_flag;
  logic        dma_error_flag;
  logic        dma_busy;
  logic [14:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_en;
  logic [1:0]  mem_we;
  logic        mem_priority;
  logic [15:0] mem_dout;
  logic        mem_ready;
  logic        mem_resp;

  // The controller is the responder: it answers the device and masters memory.
  modport slave (
    input  dma_rqst, dma_rd_wr, dma_start_address, dma_num_words, dev_ack, dev_out,
    input  mem_dout, mem_ready, mem_resp,
    output dev_in, dma_ack, dma_end_flag, dma_error_flag, dma_busy,
    output mem_addr, mem_din, mem_en, mem_we, mem_priority
  );

  modport master (
    output dma_rqst, dma_rd_wr, dma_start_address, dma_num_words, dev_ack, dev_out,
    output mem_dout, mem_ready, mem_resp,
    input  dev_in, dma_ack, dma_end_flag, dma_error_flag, dma_busy,
    input  mem_addr, mem_din, mem_en, mem_we, mem_priority
  );
endinterface
`default_nettype wire

// File: rtl/simple_dma_controller.sv
`default_nettype none
// ============================================================================
// Module      : simple_dma_controller
// Description : Moves a counted block of 16-bit words between a DMA device
//               and memory, one word per device acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module simple_dma_controller #(
  parameter logic [15:0] TIMEOUT_CYC  = 16'd1024,
  parameter logic        MEM_PRIORITY = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  simple_dma_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_DEV = 3'd1,
    S_MEM      = 3'd2,
    S_RD_CAP   = 3'd3,
    S_ACK      = 3'd4,
    S_ERR      = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [14:0] r_addr;
  logic [15:0] r_count;
  logic [15:0] r_timer;
  logic [15:0] r_dev_in;
  logic [15:0] r_mem_din;
  logic        r_dir;
  logic        w_timeout;
  logic        w_unused_addr_lsb;

  assign w_unused_addr_lsb = bus.dma_start_address[0];
  // A zero timeout setting means wait for the device forever.
  assign w_timeout = (TIMEOUT_CYC != 16'd0) && (r_timer == TIMEOUT_CYC - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.dma_rqst) begin
          w_next = (bus.dma_num_words == 16'd0) ? S_DONE : S_WAIT_DEV;
        end
      end
      S_WAIT_DEV: begin
        if (!bus.dma_rqst)    w_next = S_IDLE;
        else if (bus.dev_ack) w_next = S_MEM;
        else if (w_timeout)   w_next = S_ERR;
      end
      S_MEM: begin
        // A withdrawn request still lets the accepted access finish quietly.
        if (bus.mem_ready) begin
          if (!bus.dma_rqst)    w_next = S_IDLE;
          else if (bus.mem_resp) w_next = S_ERR;
          else if (r_dir)       w_next = S_RD_CAP;
          else                  w_next = S_ACK;
        end
      end
      S_RD_CAP: w_next = bus.dma_rqst ? S_ACK : S_IDLE;
      S_ACK:    w_next = (r_count == 16'd1) ? S_DONE : S_WAIT_DEV;
      S_ERR:    w_next = S_DONE;
      S_DONE: begin
        if (!bus.dma_rqst) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= 15'd0;
      r_count   <= 16'd0;
      r_timer   <= 16'd0;
      r_dev_in  <= 16'd0;
      r_mem_din <= 16'd0;
      r_dir     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timer <= 16'd0;
          if (bus.dma_rqst) begin
            r_addr  <= bus.dma_start_address[15:1];
            r_count <= bus.dma_num_words;
            r_dir   <= bus.dma_rd_wr;
          end
        end
        S_WAIT_DEV: begin
          if (bus.dev_ack) begin
            r_timer <= 16'd0;
            if (!r_dir) r_mem_din <= bus.dev_out;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_RD_CAP: begin
          r_timer  <= 16'd0;
          r_dev_in <= bus.mem_dout;
        end
        S_ACK: begin
          r_timer <= 16'd0;
          r_addr  <= r_addr + 15'd1;
          r_count <= r_count - 16'd1;
        end
        default: r_timer <= 16'd0;
      endcase
    end
  end

  assign bus.mem_en         = (r_state == S_MEM);
  assign bus.mem_we         = ((r_state == S_MEM) && !r_dir) ? 2'b11 : 2'b00;
  assign bus.mem_addr       = r_addr;
  assign bus.mem_din        = r_mem_din;
  assign bus.mem_priority   = MEM_PRIORITY;
  assign bus.dev_in         = r_dev_in;
  assign bus.dma_ack        = (r_state == S_ACK);
  assign bus.dma_error_flag = (r_state == S_ERR);
  assign bus.dma_end_flag   = (r_state == S_DONE);
  assign bus.dma_busy       = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule
`default_nettype wire
